// File: rtl/alu_seq_unit.sv
// Registered, valid/ready-handshaked 4-bit ALU with a stored carry flag for
// chaining multi-nibble additions, and a wrapping completed-operation counter.
module alu_seq_unit #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             use_cflag,
  input  logic [1:0]       Op,
  input  logic             l,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] R,
  output logic             z,
  output logic             c,
  output logic             s,
  output logic             c_flag,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [WIDTH:0] ONE_EXT = (WIDTH+1)'(1);

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_R;
  logic             r_z;
  logic             r_c;
  logic             r_s;
  logic             r_cFlag;
  logic [CNT_W-1:0] r_opsDone;

  logic             w_accept;
  logic             w_ci;
  logic [WIDTH:0]   w_ciExt;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;

  assign out_valid = (r_state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;

  assign R        = r_R;
  assign z        = r_z;
  assign c        = r_c;
  assign s        = r_s;
  assign c_flag   = r_cFlag;
  assign ops_done = r_opsDone;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= EMPTY;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      EMPTY:   if (w_accept) w_nextState = FULL;
      FULL:    if (out_ready && !w_accept) w_nextState = EMPTY;
      default: w_nextState = EMPTY;
    endcase
  end

  assign w_ci    = use_cflag ? r_cFlag : cin;
  assign w_ciExt = {{WIDTH{1'b0}}, w_ci};

  // Arithmetic ops share one WIDTH+1 adder; the top bit is the carry-out.
  always_comb begin
    w_sum = '0;
    case (Op)
      2'b00:   w_sum = {1'b0, A} + w_ciExt;
      2'b01:   w_sum = {1'b0, ~A} + ONE_EXT + w_ciExt;
      2'b10:   w_sum = {1'b0, A} + {1'b0, B} + w_ciExt;
      default: w_sum = {1'b0, A} + ONE_EXT + w_ciExt;
    endcase
  end

  always_comb begin
    w_res   = w_sum[WIDTH-1:0];
    w_carry = w_sum[WIDTH];
    if (l) begin
      w_carry = 1'b0;
      case (Op)
        2'b00:   w_res = A & B;
        2'b01:   w_res = A | B;
        2'b10:   w_res = A ^ B;
        default: w_res = ~A;
      endcase
    end
  end

  // Logical ops leave the chain carry untouched so chained adds survive them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_R       <= '0;
      r_z       <= 1'b0;
      r_c       <= 1'b0;
      r_s       <= 1'b0;
      r_cFlag   <= 1'b0;
      r_opsDone <= '0;
    end else if (w_accept) begin
      r_R       <= w_res;
      r_z       <= (w_res == '0);
      r_c       <= w_carry;
      r_s       <= w_res[WIDTH-1];
      r_opsDone <= r_opsDone + CNT_W'(1);
      if (!l) r_cFlag <= w_carry;
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboard bench for alu_seq_unit: the driver pushes model results on accept,
// a monitor compares every presented result and the handshake signals.
`timescale 1ns/100ps
module tb_alu_seq_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] A = '0;
  logic [3:0] B = '0;
  logic       cin = 1'b0;
  logic       use_cflag = 1'b0;
  logic [1:0] Op = '0;
  logic       l = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] R;
  logic       z, c, s, c_flag;
  logic [7:0] ops_done;

  typedef struct {
    int r; int z; int c; int s; int cf; int cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   mCflag = 0;
  int   mCnt   = 0;
  bit   running = 1'b1;

  alu_seq_unit #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .cin(cin), .use_cflag(use_cflag), .Op(Op), .l(l),
    .out_valid(out_valid), .out_ready(out_ready), .R(R), .z(z), .c(c), .s(s),
    .c_flag(c_flag), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the documented rules.
  function automatic exp_t model(input int a, input int b, input int ci, input int op, input int lg);
    exp_t e;
    int   sum;
    if (lg) begin
      case (op)
        0:       e.r = a & b;
        1:       e.r = a | b;
        2:       e.r = a ^ b;
        default: e.r = 15 - a;
      endcase
      e.c = 0;
    end else begin
      case (op)
        0:       sum = a + ci;
        1:       sum = (15 - a) + 1 + ci;
        2:       sum = a + b + ci;
        default: sum = a + 1 + ci;
      endcase
      e.r = sum % 16;
      e.c = (sum >= 16) ? 1 : 0;
    end
    e.z = (e.r == 0) ? 1 : 0;
    e.s = (e.r >= 8) ? 1 : 0;
    return e;
  endfunction

  // Drive one cycle; if the command will be accepted, push its expectation.
  task automatic applyStimulus(input bit iv, input int a, input int b, input bit ci,
                               input bit uc, input int op, input bit lg, input bit ordy);
    exp_t e;
    @(negedge clk);
    in_valid  = iv;
    A         = 4'(a);
    B         = 4'(b);
    cin       = ci;
    use_cflag = uc;
    Op        = 2'(op);
    l         = lg;
    out_ready = ordy;
    #3;
    if (iv && q.size() == 0) begin
      e = model(a, b, uc ? mCflag : int'(ci), op, lg);
      if (!lg) mCflag = e.c;
      mCnt  = (mCnt + 1) % 256;
      e.cf  = mCflag;
      e.cnt = mCnt;
      q.push_back(e);
    end
  endtask

  // Monitor: compare pending result every cycle, pop when the consumer takes it.
  initial begin
    exp_t e;
    while (running) begin
      @(negedge clk);
      #2;
      checkOutput("out_valid", int'(out_valid), (q.size() != 0) ? 1 : 0);
      checkOutput("in_ready", int'(in_ready), (q.size() == 0 || out_ready) ? 1 : 0);
      if (q.size() != 0 && out_valid) begin
        e = q[0];
        checkOutput("R", int'(R), e.r);
        checkOutput("z", int'(z), e.z);
        checkOutput("c", int'(c), e.c);
        checkOutput("s", int'(s), e.s);
        checkOutput("c_flag", int'(c_flag), e.cf);
        checkOutput("ops_done", int'(ops_done), e.cnt);
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  task automatic checkResetState();
    checkOutput("rst out_valid", int'(out_valid), 0);
    checkOutput("rst R", int'(R), 0);
    checkOutput("rst z", int'(z), 0);
    checkOutput("rst c", int'(c), 0);
    checkOutput("rst s", int'(s), 0);
    checkOutput("rst c_flag", int'(c_flag), 0);
    checkOutput("rst ops_done", int'(ops_done), 0);
  endtask

  initial begin
    #1;
    checkResetState();
    #12 reset = 1'b1;

    // Single add, then carry chain 0x0F + 0x01.
    applyStimulus(1, 7, 1, 0, 0, 2, 0, 1);
    applyStimulus(1, 15, 1, 0, 0, 2, 0, 1);
    applyStimulus(1, 0, 0, 0, 1, 2, 0, 1);
    // Negate of zero gives carry, then a logical op keeps the chain carry.
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 1);
    applyStimulus(1, 10, 0, 0, 0, 3, 1, 1);
    applyStimulus(1, 0, 0, 0, 1, 0, 0, 1);

    // Backpressure: one pending result, five stalled cycles, then release.
    applyStimulus(1, 3, 4, 1, 0, 2, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 9, 9, 0, 0, 2, 0, 0);
    applyStimulus(1, 9, 9, 0, 0, 2, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);

    // Back-to-back burst of 20 random commands.
    for (int i = 0; i < 20; i++)
      applyStimulus(1, $urandom_range(15), $urandom_range(15), 1'($urandom), 1'($urandom),
                    $urandom_range(3), 1'($urandom), 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);

    // Reset while a carry-producing result is pending.
    applyStimulus(1, 15, 1, 0, 0, 2, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checkOutput("pre-reset c_flag", int'(c_flag), 1);
    reset = 1'b0;
    q.delete();
    mCflag = 0;
    mCnt   = 0;
    #1;
    checkResetState();
    #2 reset = 1'b1;
    applyStimulus(1, 5, 2, 0, 1, 2, 0, 1);

    // Exhaustive sweep at full throughput.
    for (int lg = 0; lg < 2; lg++)
      for (int op = 0; op < 4; op++)
        for (int ci = 0; ci < 2; ci++)
          for (int uc = 0; uc < 2; uc++)
            for (int a = 0; a < 16; a++)
              for (int b = 0; b < 16; b++)
                applyStimulus(1, a, b, 1'(ci), 1'(uc), op, 1'(lg), 1);

    // Random valid/ready traffic.
    for (int i = 0; i < 3000; i++)
      applyStimulus(1'($urandom_range(3) != 0), $urandom_range(15), $urandom_range(15),
                    1'($urandom), 1'($urandom), $urandom_range(3), 1'($urandom),
                    1'($urandom_range(3) != 0));

    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("scoreboard drained", q.size(), 0);
    running = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
